// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter that serialises instruction fetches (3 bytes) and data
// loads/stores (1 byte) onto a single-port 64x8 RAM with registered outputs.
module ram_access_arbiter #(
  parameter int ADDR_W          = 6,
  parameter int DATA_W          = 8,
  parameter int LAST_FETCH_ADDR = 61
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_opcode,
  output logic [DATA_W-1:0] f_op1,
  output logic [DATA_W-1:0] f_op2,
  output logic              f_done,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              busy,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_opcode,
  input  logic [DATA_W-1:0] ram_op1,
  input  logic [DATA_W-1:0] ram_op2
);

  localparam logic [ADDR_W-1:0] LAST_FETCH = ADDR_W'(LAST_FETCH_ADDR);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t            state_q;
  logic              prio_fetch_q;
  logic              fetch_q;
  logic              we_q;
  logic [DATA_W-1:0] f_opcode_q;
  logic [DATA_W-1:0] f_op1_q;
  logic [DATA_W-1:0] f_op2_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              f_done_q;
  logic              f_err_q;
  logic              d_done_q;
  logic              busy_q;
  logic [DATA_W-1:0] ram_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;

  logic both_d;
  logic grant_f_d;
  logic grant_d_d;
  logic f_ok_d;

  // Pointer names the winner only under contention; a lone requester always wins.
  always_comb begin
    both_d    = f_req & d_req;
    grant_f_d = f_req & (~d_req | prio_fetch_q);
    grant_d_d = d_req & (~f_req | ~prio_fetch_q);
    f_ok_d    = (f_addr <= LAST_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_fetch_q <= 1'b0;
      fetch_q      <= 1'b0;
      we_q         <= 1'b0;
      f_opcode_q   <= '0;
      f_op1_q      <= '0;
      f_op2_q      <= '0;
      d_rdata_q    <= '0;
      f_done_q     <= 1'b0;
      f_err_q      <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
      ram_data_q   <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      f_done_q <= 1'b0;
      f_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (both_d) prio_fetch_q <= ~prio_fetch_q;
          // Illegal fetch start would run past the top of RAM: reject without access.
          if (grant_f_d && !f_ok_d) begin
            f_err_q <= 1'b1;
          end else if (grant_f_d) begin
            fetch_q    <= 1'b1;
            we_q       <= 1'b0;
            ram_addr_q <= f_addr;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end else if (grant_d_d) begin
            fetch_q    <= 1'b0;
            we_q       <= d_we;
            ram_addr_q <= d_addr;
            ram_data_q <= d_wdata;
            ram_we_q   <= d_we;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          state_q  <= CAPT;
        end
        CAPT: begin
          if (fetch_q) begin
            f_opcode_q <= ram_opcode;
            f_op1_q    <= ram_op1;
            f_op2_q    <= ram_op2;
          end else if (!we_q) begin
            d_rdata_q <= ram_opcode;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (fetch_q) f_done_q <= 1'b1;
          else         d_done_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_opcode = f_opcode_q;
  assign f_op1    = f_op1_q;
  assign f_op2    = f_op2_q;
  assign f_done   = f_done_q;
  assign f_err    = f_err_q;
  assign d_rdata  = d_rdata_q;
  assign d_done   = d_done_q;
  assign busy     = busy_q;
  assign ram_data = ram_data_q;
  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;

endmodule
